multicycle_datapath: RTL and testbench

Datapath half of the multicycle MIPS core. It consumes the controller's per-cycle control word (pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol) and returns op, funct and zero to it. It holds the architectural state (PC, register file) and the non-architectural stage registers (IR, Data, A, B, ALUOut). It drives the shared instruction/data memory port.

---
 rtl/multicycle_datapath.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_datapath
//  Description : Datapath half of a multicycle MIPS core. Holds the
//                architectural state (PC, 32x32 register file) and the
//                non-architectural stage registers (IR, Data, A, B, ALUOut),
//                and drives the shared instruction/data memory port. All
//                sequencing comes from the controller's per-cycle control
//                word; op/funct/zero are returned to it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   rising-edge clock
//    reset        in   1   synchronous, active-high reset
//    pcen         in   1   PC load enable
//    memwrite     in   1   memory write strobe from controller
//    irwrite      in   1   IR load enable
//    regwrite     in   1   register-file write enable
//    alusrca      in   1   SrcA select   (0: PC, 1: A)
//    iord         in   1   address select (0: PC, 1: ALUOut)
//    memtoreg     in   1   write-data select (0: ALUOut, 1: Data)
//    regdst       in   1   write-address select (0: rt, 1: rd)
//    alusrcb      in   2   SrcB select (B, 4, SignImm, SignImm<<2)
//    pcsrc        in   2   next-PC select (ALU, ALUOut, jump, hold)
//    alucontrol   in   4   ALU operation
//    readdata     in   32  memory read data (combinational memory)
//    op           out  6   IR[31:26]
//    funct        out  6   IR[5:0]
//    zero         out  1   ALU result equals zero
//    adr          out  32  memory address
//    writedata    out  32  memory write data (B register)
//    memwrite_o   out  1   memwrite forwarded to memory
// ============================================================================
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcen,
  input  logic        memwrite,
  input  logic        irwrite,
  input  logic        regwrite,
  input  logic        alusrca,
  input  logic        iord,
  input  logic        memtoreg,
  input  logic        regdst,
  input  logic [1:0]  alusrcb,
  input  logic [1:0]  pcsrc,
  input  logic [3:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero,
  output logic [31:0] adr,
  output logic [31:0] writedata,
  output logic        memwrite_o
);

  // ALU operation encodings
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_NOR = 4'b1100;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] ir_q;
  logic [31:0] data_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] aluout_q;
  logic [31:0] rf_q [32];

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] signimm;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] alu_result;
  logic [31:0] diff;
  logic [31:0] pc_jump;

  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_jump = {pc_q[31:28], ir_q[25:0], 2'b00};

  // r0 is hardwired to zero on the read side; writes to it are also dropped
  // below, so its storage cell never matters.
  assign rd1 = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  assign wa = regdst   ? rd     : rt;
  assign wd = memtoreg ? data_q : aluout_q;

  assign srca = alusrca ? a_q : pc_q;

  always_comb begin
    srcb = b_q;
    case (alusrcb)
      2'b00:   srcb = b_q;
      2'b01:   srcb = 32'd4;
      2'b10:   srcb = signimm;
      default: srcb = {signimm[29:0], 2'b00};
    endcase
  end

  assign diff = srca - srcb;

  always_comb begin
    alu_result = 32'd0;
    case (alucontrol)
      C_ALU_AND: alu_result = srca & srcb;
      C_ALU_OR:  alu_result = srca | srcb;
      C_ALU_ADD: alu_result = srca + srcb;
      C_ALU_SUB: alu_result = diff;
      // Signed less-than: when the signs differ the answer is srca's sign,
      // otherwise the subtraction cannot overflow and its sign is exact.
      C_ALU_SLT: alu_result = {31'd0, (srca[31] != srcb[31]) ? srca[31] : diff[31]};
      C_ALU_NOR: alu_result = ~(srca | srcb);
      default:   alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  always_comb begin
    pc_d = pc_q;
    case (pcsrc)
      2'b00:   pc_d = alu_result;
      2'b01:   pc_d = aluout_q;
      2'b10:   pc_d = pc_jump;
      default: pc_d = pc_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign op         = ir_q[31:26];
  assign funct      = ir_q[5:0];
  assign adr        = iord ? aluout_q : pc_q;
  assign writedata  = b_q;
  assign memwrite_o = memwrite;

  // --------------------------------------------------------------------------
  // PC and stage registers. Reset wins over every enable, so an instruction
  // interrupted by reset leaves nothing behind in these registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      data_q   <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
    end else begin
      if (pcen) begin
        pc_q <= pc_d;
      end
      // IR captures memory at the pre-edge address even when the PC
      // advances on the same edge.
      if (irwrite) begin
        ir_q <= readdata;
      end
      data_q   <= readdata;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= alu_result;
    end
  end

  // --------------------------------------------------------------------------
  // Register file write port. Not reset; contents written before a reset
  // survive it. A same-cycle read still sees the old value because A/B
  // sample rd1/rd2 on the same edge that commits the write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && regwrite && (wa != 5'd0)) begin
      rf_q[wa] <= wd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_datapath
//  Description : Directed bench for multicycle_datapath. Drives hand-built
//                control words cycle by cycle and compares the memory port,
//                op/funct and zero against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcen, memwrite, irwrite, regwrite;
  logic        alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [3:0]  alucontrol;
  logic [31:0] readdata;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;
  logic        memwrite_o;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_datapath #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .readdata   (readdata),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .adr        (adr),
    .writedata  (writedata),
    .memwrite_o (memwrite_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; pcen = 1'b0; memwrite = 1'b0; irwrite = 1'b0; regwrite = 1'b0;
    alusrca = 1'b0; iord = 1'b0; memtoreg = 1'b0; regdst = 1'b0;
    alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = C_ADD; readdata = 32'd0;
  endtask

  // Let combinational outputs settle after changing inputs.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle();
    pcen = 1'b1; irwrite = 1'b1; alusrcb = 2'b01; alucontrol = C_ADD;
    readdata = instr;
    tick();
  endtask

  task automatic decode();
    idle();
    alusrcb = 2'b11; alucontrol = C_ADD;
    tick();
  endtask

  // ALUOut <= A op B, then observe ALUOut through adr with iord=1.
  task automatic alu_ab(input string tag, input logic [3:0] code, input logic [31:0] exp);
    idle();
    alusrca = 1'b1; alusrcb = 2'b00; alucontrol = code;
    tick();
    idle();
    iord = 1'b1;
    settle();
    check(tag, adr, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    @(negedge clk);

    // ---- Reset with enables active: reset must win ----
    reset = 1'b1; pcen = 1'b1; irwrite = 1'b1; regwrite = 1'b1; readdata = 32'h8C08_0004;
    alusrcb = 2'b01;
    tick();
    tick();
    idle();
    settle();
    check("rst_adr",   adr,       32'h0);
    check("rst_op",    {26'd0, op},    32'h0);
    check("rst_funct", {26'd0, funct}, 32'h0);
    check("rst_wdata", writedata, 32'h0);

    // ---- LW r8,4(r0) at PC=0 ----
    fetch(32'h8C08_0004);
    check("lw_op",    {26'd0, op},    32'h23);
    check("lw_funct", {26'd0, funct}, 32'h04);
    decode();
    idle(); alusrca = 1'b1; alusrcb = 2'b10; alucontrol = C_ADD;   // memadr
    tick();
    idle(); iord = 1'b1; readdata = 32'hDEAD_BEEF;                  // mem read
    settle();
    check("lw_memadr", adr, 32'h4);
    tick();
    idle(); regdst = 1'b0; memtoreg = 1'b1; regwrite = 1'b1;        // writeback
    tick();
    idle();
    settle();
    check("lw_pc", adr, 32'h4);

    // ---- ADDI r9,r0,5 at PC=4 ----
    fetch(32'h2009_0005);
    check("addi_op", {26'd0, op}, 32'h08);
    decode();
    idle(); alusrca = 1'b1; alusrcb = 2'b10; alucontrol = C_ADD;
    tick();
    idle(); regwrite = 1'b1;
    tick();

    // ---- ADD r10,r8,r9 at PC=8 ----
    fetch(32'h0109_5020);
    check("add_funct", {26'd0, funct}, 32'h20);
    decode();
    check("add_b_r9", writedata, 32'h5);
    idle(); alusrca = 1'b1; alusrcb = 2'b00; alucontrol = C_ADD;
    tick();
    // Writeback while the ALU evaluates SLT(r8,r9): the write uses the
    // pre-edge ALUOut, and r8 is negative so the result is 1.
    idle(); regdst = 1'b1; regwrite = 1'b1; alusrca = 1'b1; alusrcb = 2'b00; alucontrol = C_SLT;
    settle();
    check("slt_r8_r9_zero", {31'd0, zero}, 32'h0);
    tick();

    // ---- R-type rs=r9 rt=r10 at PC=12: read r10, ALU sweep on (5, r10) ----
    fetch(32'h012A_002A);
    decode();
    check("r10_value", writedata, 32'hDEAD_BEF4);
    idle(); alusrca = 1'b1; alusrcb = 2'b00; alucontrol = C_SLT;
    settle();
    check("slt_r9_r10_zero", {31'd0, zero}, 32'h1);
    alu_ab("alu_and", C_AND,   32'h0000_0004);
    alu_ab("alu_or",  C_OR,    32'hDEAD_BEF5);
    alu_ab("alu_add", C_ADD,   32'hDEAD_BEF9);
    alu_ab("alu_sub", C_SUB,   32'h2152_4111);
    alu_ab("alu_slt", C_SLT,   32'h0000_0000);
    alu_ab("alu_nor", C_NOR,   32'h2152_410A);
    alu_ab("alu_bad", 4'b0011, 32'h0000_0000);
    idle(); memwrite = 1'b1;
    settle();
    check("memwrite_o", {31'd0, memwrite_o}, 32'h1);

    // ---- BEQ r0,r0,+3 at PC=16 -> 20+12 = 32 ----
    idle();
    settle();
    check("beq_pc_before", adr, 32'd16);
    fetch(32'h1000_0003);
    decode();
    idle(); alusrca = 1'b1; alusrcb = 2'b00; alucontrol = C_SUB; pcen = 1'b1; pcsrc = 2'b01;
    settle();
    check("beq_zero", {31'd0, zero}, 32'h1);
    tick();
    idle();
    settle();
    check("beq_taken_pc", adr, 32'd32);

    // ---- BEQ r8,r9,+3 at PC=32: not taken, PC stays 36 ----
    fetch(32'h1109_0003);
    decode();
    idle(); alusrca = 1'b1; alusrcb = 2'b00; alucontrol = C_SUB; pcsrc = 2'b01;
    settle();
    check("bne_zero", {31'd0, zero}, 32'h0);
    tick();
    idle();
    settle();
    check("bne_pc", adr, 32'd36);

    // ---- J 0x40 at PC=36 ----
    fetch(32'h0800_0010);
    decode();
    idle(); pcen = 1'b1; pcsrc = 2'b10;
    tick();
    idle();
    settle();
    check("j_pc", adr, 32'h40);

    // ---- ADDI r0,r0,7: write to r0 must be dropped ----
    fetch(32'h2000_0007);
    decode();
    idle(); alusrca = 1'b1; alusrcb = 2'b10; alucontrol = C_ADD;
    tick();
    idle(); iord = 1'b1;
    settle();
    check("r0_aluout", adr, 32'h7);
    idle(); regwrite = 1'b1;
    tick();
    idle();
    tick();
    check("r0_b", writedata, 32'h0);
    idle(); alusrca = 1'b1; alusrcb = 2'b00; alucontrol = C_ADD;
    settle();
    check("r0_a_plus_b_zero", {31'd0, zero}, 32'h1);

    // ---- Mid-instruction reset in the memadr cycle of LW at PC=0x44 ----
    fetch(32'h8C08_0004);
    decode();
    idle(); reset = 1'b1; alusrca = 1'b1; alusrcb = 2'b10; alucontrol = C_ADD; pcen = 1'b1;
    tick();
    idle(); iord = 1'b1;
    settle();
    check("midrst_aluout", adr, 32'h0);
    iord = 1'b0;
    settle();
    check("midrst_pc", adr, 32'h0);
    check("midrst_op", {26'd0, op}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
